// File: rtl/full_adder_behave.sv
// full_adder_behave: 1-bit full adder leaf cell for the S3 logic lab datapath library.
//
// The sum and carry outputs are purely combinational and need no clock. Registered
// copies of both, plus a saturating count of carry-generating cycles, are kept on clk.
//
// Optional build macro: FA_SELF_CHECK_EN
//   defined   - a gate-level twin (XOR/AND/OR primitives) runs beside the behavioural
//               adder; any disagreement seen on a clk edge sets the sticky fa_err flag.
//   undefined - no twin is built and fa_err is tied to 0.
//   The port list is the same in both builds.
//
// Parameters:
//   CNT_W        width of carry_cnt in bits (2..16)
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   A_input      in   1      addend A
//   B_input      in   1      addend B
//   Cin_input    in   1      carry in
//   S_output     out  1      combinational sum, A ^ B ^ Cin
//   Cout_output  out  1      combinational carry, A&B | Cin&(A^B)
//   S_q          out  1      S_output registered on clk
//   Cout_q       out  1      Cout_output registered on clk
//   carry_cnt    out  CNT_W  saturating count of cycles with Cout_output = 1
//   fa_err       out  1      sticky self-check mismatch flag (0 when the twin is absent)

module full_adder_behave #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A_input,
    input  logic             B_input,
    input  logic             Cin_input,
    output logic             S_output,
    output logic             Cout_output,
    output logic             S_q,
    output logic             Cout_q,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             fa_err
);

    // Behavioural adder: {Cout,S} is the 2-bit arithmetic sum. X/Z on any input flows
    // straight through the addition, which is the intended behaviour.
    logic [1:0] sum;

    always_comb begin
        sum = {1'b0, A_input} + {1'b0, B_input} + {1'b0, Cin_input};
    end

    assign S_output    = sum[0];
    assign Cout_output = sum[1];

    // Registered copies of the combinational outputs.
    logic sum_q;
    logic carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= S_output;
            carry_q <= Cout_output;
        end
    end

    assign S_q    = sum_q;
    assign Cout_q = carry_q;

    // Carry counter, holds at all-ones instead of wrapping.
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (Cout_output && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carry_cnt = cnt_q;

`ifdef FA_SELF_CHECK_EN
    // Gate-level twin, structurally independent of the arithmetic form above.
    logic twin_p;
    logic twin_g;
    logic twin_t;
    logic twin_s;
    logic twin_c;

    xor u_xor_p (twin_p, A_input, B_input);
    xor u_xor_s (twin_s, twin_p, Cin_input);
    and u_and_g (twin_g, A_input, B_input);
    and u_and_t (twin_t, Cin_input, twin_p);
    or  u_or_c  (twin_c, twin_g, twin_t);

    logic mismatch;
    logic err_q;

    always_comb begin
        mismatch = (twin_s != S_output) || (twin_c != Cout_output);
    end

    // Sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (mismatch) begin
            err_q <= 1'b1;
        end
    end

    assign fa_err = err_q;
`else
    assign fa_err = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder_behave.sv
// Self-checking bench for full_adder_behave.
// Two instances share all inputs: the default CNT_W=8 build and a CNT_W=2 build used
// to reach counter saturation quickly. Expected values come from an arithmetic model.

module tb_full_adder_behave;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       cin;
    logic       run_clk;

    logic       s8;
    logic       c8;
    logic       sq8;
    logic       cq8;
    logic [7:0] cnt8;
    logic       err8;

    logic       s2;
    logic       c2;
    logic       sq2;
    logic       cq2;
    logic [1:0] cnt2;
    logic       err2;

    full_adder_behave u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .A_input     (a),
        .B_input     (b),
        .Cin_input   (cin),
        .S_output    (s8),
        .Cout_output (c8),
        .S_q         (sq8),
        .Cout_q      (cq8),
        .carry_cnt   (cnt8),
        .fa_err      (err8)
    );

    full_adder_behave #(
        .CNT_W (2)
    ) u_dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .A_input     (a),
        .B_input     (b),
        .Cin_input   (cin),
        .S_output    (s2),
        .Cout_output (c2),
        .S_q         (sq2),
        .Cout_q      (cq2),
        .carry_cnt   (cnt2),
        .fa_err      (err2)
    );

    // Clock only toggles when enabled, so the first sweep really has no clock.
    initial clk = 1'b0;
    always begin
        #5;
        if (run_clk) clk = ~clk;
    end

    int unsigned n_tests;
    int unsigned n_fail;

    // Reference model state.
    int exp_sq;
    int exp_cq;
    int exp_cnt8;
    int exp_cnt2;
    int exp_err;
    bit inject;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int add3();
        return int'(a) + int'(b) + int'(cin);
    endfunction

    // Drive a pattern {A,B,Cin} and check both combinational outputs of both instances.
    task automatic apply(input logic [2:0] pat);
        int sum;
        {a, b, cin} = pat;
        #1;
        sum = add3();
        check("s_comb", 32'(s8), 32'(sum % 2));
        check("cout_comb", 32'(c8), 32'(sum / 2));
        check("s_comb_w2", 32'(s2), 32'(sum % 2));
        check("cout_comb_w2", 32'(c2), 32'(sum / 2));
    endtask

    task automatic check_regs();
        check("s_q", 32'(sq8), 32'(exp_sq));
        check("cout_q", 32'(cq8), 32'(exp_cq));
        check("carry_cnt", 32'(cnt8), 32'(exp_cnt8));
        check("fa_err", 32'(err8), 32'(exp_err));
        check("s_q_w2", 32'(sq2), 32'(exp_sq));
        check("cout_q_w2", 32'(cq2), 32'(exp_cq));
        check("carry_cnt_w2", 32'(cnt2), 32'(exp_cnt2));
        check("fa_err_w2", 32'(err2), 32'd0);
    endtask

    // Advance one clock edge; the model captures the inputs present at that edge.
    task automatic tick();
        int sum;
        @(posedge clk);
        if (rst_n) begin
            sum    = add3();
            exp_sq = sum % 2;
            exp_cq = sum / 2;
            if (sum >= 2) begin
                if (exp_cnt8 < 255) exp_cnt8++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
            if (inject) exp_err = 1;
        end
        #1;
    endtask

    task automatic model_reset();
        exp_sq   = 0;
        exp_cq   = 0;
        exp_cnt8 = 0;
        exp_cnt2 = 0;
        exp_err  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] sweep [8];
        int         sat_exp [5];

        n_tests = 0;
        n_fail  = 0;
        inject  = 1'b0;
        run_clk = 1'b0;
        a       = 1'b0;
        b       = 1'b0;
        cin     = 1'b0;
        rst_n   = 1'b1;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs();

        // Combinational sweep with no clock and reset held.
        sweep = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111, 3'b101, 3'b110};
        for (int i = 0; i < 8; i++) begin
            apply(sweep[i]);
            #9;
        end
        check_regs();

        // Start the clock; registers must stay cleared while reset is low.
        run_clk = 1'b1;
        tick();
        tick();
        check_regs();

        // Registered path.
        rst_n = 1'b1;
        apply(3'b111);
        tick();
        check_regs();
        apply(3'b000);
        check_regs();
        #2;
        check_regs();
        tick();
        check_regs();

        // Asynchronous reset mid-cycle, no clock edge needed.
        apply(3'b110);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs();
        apply(3'b011);
        tick();
        apply(3'b101);
        tick();
        check_regs();

        // Release mid-cycle, then check saturation of the 2-bit counter.
        rst_n = 1'b1;
        apply(3'b110);
        sat_exp = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sat_table_w2", 32'(cnt2), 32'(sat_exp[i]));
            check_regs();
        end

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            apply(3'($urandom_range(0, 7)));
            tick();
            check_regs();
        end

        // Drive the 8-bit counter into saturation.
        apply(3'b111);
        for (int i = 0; i < 260; i++) begin
            tick();
            check_regs();
        end
        check("sat_w8", 32'(cnt8), 32'd255);

`ifdef FA_SELF_CHECK_EN
        // Twin agrees on every pattern, then a forced twin fault latches fa_err.
        for (int i = 0; i < 8; i++) begin
            apply(3'(i));
            tick();
            check_regs();
        end
        apply(3'b000);
        force u_dut.twin_s = 1'b1;
        inject = 1'b1;
        tick();
        release u_dut.twin_s;
        inject = 1'b0;
        check_regs();
        for (int i = 0; i < 4; i++) begin
            apply(3'(i * 2 + 1));
            tick();
            check_regs();
        end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs();
        rst_n = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
